bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO byte entries (a power of two, at least 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning bit order (1 = bit 7 first, 0 = bit 0 first).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port s_valid, input, 1 bit: upstream byte valid.
REQ-006 The block SHALL have port s_data, input, 8 bits: upstream byte.
REQ-007 The block SHALL have port s_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port ser_out, output, 1 bit: serial bit stream that drives the sequence detector's in.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a payload bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: FIFO non-empty or a byte is in flight.
REQ-011 The block SHALL have port byte_cnt, output, 16 bits: number of bytes fully serialized.

Function
REQ-012 The block SHALL accept a byte on a clock edge where s_valid && s_ready, writing s_data at the write pointer.
REQ-013 s_ready SHALL be combinational: count < DEPTH; a push while full SHALL NOT occur, and no push-through SHALL occur when full.
REQ-014 Read and write pointers SHALL be log2(DEPTH) bits wide, wrap modulo DEPTH, and be paired with a count of 0..DEPTH.
REQ-015 A push and a pop on the same edge SHALL leave count unchanged.
REQ-016 The serializer FSM SHALL have two states, IDLE and SHIFT, with a 3-bit bit index and an 8-bit shift register.
REQ-017 In IDLE with count > 0, the block SHALL pop the head byte and, on the same edge, register the first bit onto ser_out, set ser_valid=1, set the index to 1, and move to SHIFT.
REQ-018 In SHIFT with index 1..7, each edge SHALL register the next bit onto ser_out and increment the index.
REQ-019 In SHIFT on the edge after the 8th bit is presented, byte_cnt SHALL increment, wrapping modulo 2^16, and:
- if count > 0: the block SHALL pop the next byte and present its first bit on that edge, with no gap cycle;
- else: ser_out SHALL become 0, ser_valid SHALL become 0, and the FSM SHALL return to IDLE.
REQ-020 ser_out SHALL be 0 whenever ser_valid is 0; the idle fill SHALL be constant 0.
REQ-021 Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, the first bit SHALL appear after edge N+1 and the last bit after edge N+8.
REQ-022 A byte pushed on the same edge that the FIFO is empty and the FSM pops SHALL NOT be seen by that pop; it SHALL be popped on a later edge.
REQ-023 busy SHALL be combinational: (count != 0) || ser_valid.
REQ-024 Sustained throughput SHALL be one bit per cycle, i.e. one byte per 8 cycles.

Reset
REQ-025 While rstn=0 at an edge, the block SHALL clear pointers, count, index, shift register and byte_cnt, and set the FSM to IDLE, ser_out=0 and ser_valid=0.
REQ-026 Reset mid-byte SHALL discard the partial byte and all queued bytes, and no further bits of them SHALL be emitted.
REQ-027 While rstn=0, s_ready SHALL be 1 (count=0), and pushes presented during reset SHALL be dropped.

Verification
REQ-028 Push 0xB0 with MSB_FIRST=1 -> ser_out = 1,0,1,1,0,0,0,0 on cycles N+1..N+8; ser_valid high for exactly 8 cycles; byte_cnt = 1; a downstream 1011 detector out pulses once.
REQ-029 Push 0x0B then 0x0B back-to-back -> 16 contiguous valid bits with no gap; byte_cnt = 2.
REQ-030 Hold s_valid=1 with bytes 0x01..0x06 -> s_ready falls after 5 accepts (1 in shifter, 4 queued); all 6 bytes are emitted in order; pointers wrap correctly.
REQ-031 Assert rstn=0 for 1 cycle at bit 3 of 0xFF with 2 bytes queued -> ser_valid=0, ser_out=0, busy=0 the next cycle, and no further bits are emitted.
REQ-032 Push 0x80 with MSB_FIRST=0 -> ser_out = 0,0,0,0,0,0,0,1.
REQ-033 A push on the same edge as the final-bit pop with count=0 -> one idle cycle (ser_valid=0), then the new byte is emitted.

Source files
------------

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Byte FIFO followed by a parallel-to-serial shifter. Bytes are accepted
//   with a valid/ready handshake, queued, and emitted one bit per clock on
//   ser_out. Back-to-back bytes are emitted with no gap cycle.
//
// Parameters
//   DEPTH      number of FIFO byte entries (power of two, >= 2)
//   MSB_FIRST  1: bit 7 is emitted first, 0: bit 0 is emitted first
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rstn       synchronous active-low reset
//   s_valid    upstream byte valid
//   s_data     upstream byte
//   s_ready    FIFO can accept a byte this cycle (combinational)
//   ser_out    serial bit stream, 0 whenever ser_valid is 0
//   ser_valid  ser_out carries a payload bit this cycle
//   busy       FIFO non-empty or a byte in flight (combinational)
//   byte_cnt   number of bytes fully serialized, wraps at 2^16
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        busy,
    output logic [15:0] byte_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          push;
    logic          pop;
    logic          byte_done;
    logic [7:0]    head;
    logic          load_bit;
    logic [7:0]    load_rest;
    logic          next_bit;
    logic [7:0]    next_rest;

    // Held high during reset so upstream never sees a stall there; the push
    // itself is still gated by rstn so those bytes are dropped.
    assign s_ready = !rstn || (count < DEPTH_C);
    assign push    = rstn && s_valid && s_ready;
    assign busy    = (count != '0) || ser_valid;

    // bit_idx wraps 7 -> 0 after the 8th bit, so SHIFT with index 0 marks
    // the edge that retires the byte in flight.
    assign byte_done = (state == SHIFT) && (bit_idx == 3'd0);

    // The pop uses the pre-edge count, so a byte pushed into an empty FIFO
    // on this edge is not visible to it.
    assign pop  = (count != '0) && ((state == IDLE) || byte_done);
    assign head = mem[rd_ptr];

    // Bit selection for a freshly loaded byte and for the running shifter.
    // The remaining bits are kept pre-shifted so the next bit is always at
    // a fixed position.
    always_comb begin
        load_bit  = 1'b0;
        load_rest = 8'h00;
        next_bit  = 1'b0;
        next_rest = 8'h00;
        if (MSB_FIRST) begin
            load_bit  = head[7];
            load_rest = {head[6:0], 1'b0};
            next_bit  = shreg[7];
            next_rest = {shreg[6:0], 1'b0};
        end else begin
            load_bit  = head[0];
            load_rest = {1'b0, head[7:1]};
            next_bit  = shreg[0];
            next_rest = {1'b0, shreg[7:1]};
        end
    end

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            byte_cnt  <= 16'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        ser_out   <= load_bit;
                        ser_valid <= 1'b1;
                        shreg     <= load_rest;
                        bit_idx   <= 3'd1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!byte_done) begin
                        ser_out <= next_bit;
                        shreg   <= next_rest;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (pop) begin
                            ser_out   <= load_bit;
                            ser_valid <= 1'b1;
                            shreg     <= load_rest;
                            bit_idx   <= 3'd1;
                        end else begin
                            ser_out   <= 1'b0;
                            ser_valid <= 1'b0;
                            shreg     <= 8'h00;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Self-checking bench for bit_serializer. Two instances (MSB-first and
//   LSB-first) share the same stimulus. A byte/queue level reference model
//   predicts every output each cycle; a vector table and hand-written
//   sequences cover the directed scenarios.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic [7:0]  s_data;

    logic        s_ready_m, ser_out_m, ser_valid_m, busy_m;
    logic [15:0] byte_cnt_m;
    logic        s_ready_l, ser_out_l, ser_valid_l, busy_l;
    logic [15:0] byte_cnt_l;

    bit_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .busy(busy_m), .byte_cnt(byte_cnt_m)
    );

    bit_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .busy(busy_l), .byte_cnt(byte_cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus the byte being emitted
    // and how many of its bits have been shown so far.
    logic [7:0]  mq[$];
    logic [7:0]  mcur;
    int          mk;
    logic        mvalid;
    logic [15:0] mcnt;

    function automatic logic exp_bit(input bit msb);
        if (!mvalid) return 1'b0;
        return msb ? mcur[8-mk] : mcur[mk-1];
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        bit pushok;
        if (!r) begin
            mq.delete();
            mvalid = 1'b0;
            mk     = 0;
            mcnt   = 16'd0;
            return;
        end
        pushok = v && (mq.size() < DEPTH);
        if (mvalid && mk < 8) begin
            mk++;
        end else begin
            if (mvalid) mcnt++;
            if (mq.size() > 0) begin
                mcur   = mq.pop_front();
                mk     = 1;
                mvalid = 1'b1;
            end else begin
                mvalid = 1'b0;
            end
        end
        if (pushok) mq.push_back(d);
    endtask

    // Values observed at the negedge of the most recent cycle.
    logic        cap_ready, cap_valid, cap_out, cap_lsb, cap_lvalid, cap_busy;
    logic [15:0] cap_cnt;
    bit          chk_en = 1'b0;
    logic [3:0]  det;
    int          det_hits;

    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        rstn    = r;
        s_valid = v;
        s_data  = d;
        @(negedge clk);
        cap_ready  = s_ready_m;
        cap_valid  = ser_valid_m;
        cap_out    = ser_out_m;
        cap_lsb    = ser_out_l;
        cap_lvalid = ser_valid_l;
        cap_busy   = busy_m;
        cap_cnt    = byte_cnt_m;
        if (chk_en) begin
            check("model_s_ready",   32'(s_ready_m),   32'(!r || (mq.size() < DEPTH)));
            check("model_ser_valid", 32'(ser_valid_m), 32'(mvalid));
            check("model_ser_out",   32'(ser_out_m),   32'(exp_bit(1'b1)));
            check("model_busy",      32'(busy_m),      32'((mq.size() != 0) || mvalid));
            check("model_byte_cnt",  32'(byte_cnt_m),  32'(mcnt));
            check("model_lsb_valid", 32'(ser_valid_l), 32'(mvalid));
            check("model_lsb_out",   32'(ser_out_l),   32'(exp_bit(1'b0)));
            check("model_lsb_cnt",   32'(byte_cnt_l),  32'(mcnt));
            if (cap_valid) begin
                det = {det[2:0], cap_out};
                if (det == 4'b1011) det_hits++;
            end
        end
        model_step(r, v, d);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        e_rdy;
        logic        e_vld;
        logic        e_out;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0]  pat;
        logic [15:0] base;
        logic [15:0] bits16;
        logic [47:0] bits48;
        logic [47:0] exp48;
        logic [7:0]  lsb_exp;
        int          nvalid, span, first_i, last_i;
        int          idx, accepts, first_block, guard, nb;

        rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        mvalid = 1'b0; mk = 0; mcnt = 16'd0; mcur = 8'h00;
        det = 4'h0; det_hits = 0;

        // Reset with pushes offered; these must be dropped.
        repeat (3) cyc(1'b0, 1'b1, 8'h55);
        chk_en = 1'b1;

        // Directed table: reset state, then 0xB0 MSB-first.
        pat = 8'hB0;
        tbl[0] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        for (int i = 0; i < 8; i++)
            tbl[3+i] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, pat[7-i], 1'b1, 16'd0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};

        for (int i = 0; i < 13; i++) begin
            if (i == 1) begin det = 4'h0; det_hits = 0; end
            cyc(tbl[i].r, tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_s_ready", i),   32'(cap_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_ser_valid", i), 32'(cap_valid), 32'(tbl[i].e_vld));
            check($sformatf("tbl%0d_ser_out", i),   32'(cap_out),   32'(tbl[i].e_out));
            check($sformatf("tbl%0d_busy", i),      32'(cap_busy),  32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_byte_cnt", i),  32'(cap_cnt),   32'(tbl[i].e_cnt));
        end
        check("b0_detector_pulses", 32'(det_hits), 32'd1);

        // Two 0x0B bytes back to back: 16 contiguous bits.
        base = cap_cnt;
        bits16 = 16'h0; nvalid = 0; first_i = -1; last_i = -1;
        cyc(1'b1, 1'b1, 8'h0B);
        cyc(1'b1, 1'b1, 8'h0B);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (cap_valid) begin
                bits16 = {bits16[14:0], cap_out};
                nvalid++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
        span = (first_i < 0) ? 0 : (last_i - first_i + 1);
        check("b2b_valid_bits", 32'(nvalid), 32'd16);
        check("b2b_contiguous", 32'(span), 32'd16);
        check("b2b_data", 32'(bits16), 32'h0B0B);
        check("b2b_byte_cnt_delta", 32'(cap_cnt - base), 32'd2);

        // Hold s_valid with 0x01..0x06: backpressure after 5 accepts.
        idx = 1; accepts = 0; first_block = -1; guard = 0; nb = 0; bits48 = '0;
        while ((idx <= 6 || cap_busy) && guard < 200) begin
            cyc(1'b1, idx <= 6, 8'(idx));
            if (idx <= 6 && cap_ready) begin
                idx++;
                accepts++;
            end else if (idx <= 6 && !cap_ready && first_block < 0) begin
                first_block = accepts;
            end
            if (cap_valid) begin
                bits48 = {bits48[46:0], cap_out};
                nb++;
            end
            guard++;
        end
        exp48 = 48'h010203040506;
        check("fill_timeout", 32'(guard >= 200), 32'd0);
        check("fill_accepts_before_stall", 32'(first_block), 32'd5);
        check("fill_bit_count", 32'(nb), 32'd48);
        check("fill_data_hi", 32'(bits48[47:24]), 32'(exp48[47:24]));
        check("fill_data_lo", 32'(bits48[23:0]), 32'(exp48[23:0]));

        // Reset at bit 3 of 0xFF with two bytes queued.
        cyc(1'b1, 1'b1, 8'hFF);
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b1, 8'h22);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("rst_mid_pre_valid", 32'(cap_valid), 32'd1);
        check("rst_mid_pre_out", 32'(cap_out), 32'd1);
        check("rst_mid_ready_in_reset", 32'(cap_ready), 32'd1);
        cyc(1'b1, 1'b0, 8'h00);
        check("rst_mid_valid", 32'(cap_valid), 32'd0);
        check("rst_mid_out", 32'(cap_out), 32'd0);
        check("rst_mid_busy", 32'(cap_busy), 32'd0);
        check("rst_mid_cnt", 32'(cap_cnt), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (cap_valid || cap_lvalid) nvalid++;
        end
        check("rst_mid_no_more_bits", 32'(nvalid), 32'd0);

        // 0x80 LSB-first: seven zeros then a one.
        lsb_exp = 8'b0000_0001;
        cyc(1'b1, 1'b1, 8'h80);
        cyc(1'b1, 1'b0, 8'h00);
        check("lsb80_latency_gap", 32'(cap_lvalid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            check($sformatf("lsb80_valid%0d", i), 32'(cap_lvalid), 32'd1);
            check($sformatf("lsb80_bit%0d", i), 32'(cap_lsb), 32'(lsb_exp[7-i]));
        end
        cyc(1'b1, 1'b0, 8'h00);
        check("lsb80_end_valid", 32'(cap_lvalid), 32'd0);

        // Push on the same edge as the end-of-byte pop with empty FIFO.
        cyc(1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h5A);
        check("late_push_last_bit_valid", 32'(cap_valid), 32'd1);
        check("late_push_last_bit", 32'(cap_out), 32'd1);
        cyc(1'b1, 1'b0, 8'h00);
        check("late_push_idle_gap", 32'(cap_valid), 32'd0);
        check("late_push_busy_in_gap", 32'(cap_busy), 32'd1);
        cyc(1'b1, 1'b0, 8'h00);
        check("late_push_resume_valid", 32'(cap_valid), 32'd1);
        check("late_push_resume_bit", 32'(cap_out), 32'd0);
        repeat (10) cyc(1'b1, 1'b0, 8'h00);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            int pct;
            case ((i / 256) % 4)
                0: pct = 20;
                1: pct = 50;
                2: pct = 90;
                default: pct = 100;
            endcase
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pct,
                8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
